vertices_buffer_loader: RTL and testbench

Write-side companion of the vertices buffer read address generator. Accepts a stream of vertex words from the host/upstream interface over a valid/ready handshake, writes them sequentially into the vertices buffer from address 0, and publishes the final written address as `last_addr` for the read side. It signals completion with `done` and flags buffer overflow with `overflow`.

---
 rtl/vertices_buffer_loader_if.sv | 29 ++
 rtl/vertices_buffer_loader.sv | 91 +++++++++
 tb/tb_vertices_buffer_loader.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vertices_buffer_loader_if.sv
// Upstream word stream plus buffer write bus for the vertices buffer loader.
// A word moves only in a cycle where in_valid & in_ready are both high; in_data and in_last are meaningful only with in_valid.
interface vertices_buffer_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic                  done;
  logic                  overflow;
  logic                  busy;

  modport master (
    output start, in_valid, in_data, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata, last_addr, done, overflow, busy
  );

  modport slave (
    input  start, in_valid, in_data, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata, last_addr, done, overflow, busy
  );
endinterface

// File: rtl/vertices_buffer_loader.sv
// Writes an upstream vertex word stream into the vertices buffer from address 0
// and publishes the final written address for the read-side address generator.
module vertices_buffer_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  vertices_buffer_loader_if.slave  bus,
  output logic [2:0]               dbg_state
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [ADDR_WIDTH-1:0] last_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      last_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          mem_we <= 1'b0;
          if (bus.start) begin
            state  <= S_LOAD;
            wr_ptr <= '0;
          end
        end
        S_LOAD: begin
          // in_ready is high throughout LOAD, so in_valid alone marks an accept.
          if (bus.in_valid) begin
            mem_we    <= 1'b1;
            mem_addr  <= wr_ptr;
            mem_wdata <= bus.in_data;
            if (bus.in_last) begin
              state     <= S_FLUSH;
              last_addr <= wr_ptr;
            end else if (wr_ptr == ADDR_MAX) begin
              state     <= S_ERROR;
              last_addr <= ADDR_MAX;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end else begin
            mem_we <= 1'b0;
          end
        end
        S_FLUSH: begin
          mem_we <= 1'b0;
          state  <= S_DONE;
        end
        S_DONE, S_ERROR: begin
          mem_we <= 1'b0;
          if (bus.start) begin
            state  <= S_LOAD;
            wr_ptr <= '0;
          end
        end
        default: begin
          mem_we <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == S_LOAD);
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.last_addr = last_addr;
  assign bus.done      = (state == S_DONE);
  assign bus.overflow  = (state == S_ERROR);
  assign bus.busy      = (state == S_LOAD) || (state == S_FLUSH);
  assign dbg_state     = state;
endmodule

// File: tb/tb_vertices_buffer_loader.sv
// Bench for vertices_buffer_loader: an 8-bit-address and a 4-bit-address instance share stimulus;
// one of them is selected for checking per scenario.
module tb_vertices_buffer_loader;
  logic clk = 1'b0;
  logic rst;
  logic start, in_valid, in_last;
  logic [31:0] in_data;
  logic sel;
  logic [2:0] st8, st4;

  always #5 clk = ~clk;

  vertices_buffer_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if8 ();
  vertices_buffer_loader_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) if4 ();

  assign if8.start = start;  assign if4.start = start;
  assign if8.in_valid = in_valid;  assign if4.in_valid = in_valid;
  assign if8.in_data = in_data;  assign if4.in_data = in_data;
  assign if8.in_last = in_last;  assign if4.in_last = in_last;

  vertices_buffer_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut8 (
    .clk(clk), .rst(rst), .bus(if8), .dbg_state(st8));
  vertices_buffer_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut4 (
    .clk(clk), .rst(rst), .bus(if4), .dbg_state(st4));

  // Selected instance's outputs, addresses zero-extended to 8 bits
  logic we_s, rdy_s, done_s, ovf_s, busy_s;
  logic [7:0] addr_s, last_s;
  logic [31:0] data_s;
  logic [2:0] st_s;
  always_comb begin
    we_s = if8.mem_we;  rdy_s = if8.in_ready;  done_s = if8.done;
    ovf_s = if8.overflow;  busy_s = if8.busy;  addr_s = if8.mem_addr;
    last_s = if8.last_addr;  data_s = if8.mem_wdata;  st_s = st8;
    if (sel) begin
      we_s = if4.mem_we;  rdy_s = if4.in_ready;  done_s = if4.done;
      ovf_s = if4.overflow;  busy_s = if4.busy;  addr_s = {4'b0, if4.mem_addr};
      last_s = {4'b0, if4.last_addr};  data_s = if4.mem_wdata;  st_s = st4;
    end
  end

  int checks = 0;
  int errors = 0;
  int wr_seen = 0;
  logic [39:0] exp_q[$];
  logic [7:0] exp_ptr;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every write on the selected bus must match the oldest expected {addr, data}
  always @(negedge clk) begin
    if (we_s === 1'b1) begin
      logic [39:0] e;
      wr_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write at %0t", addr_s, data_s, $time);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", {32'b0, addr_s}, {32'b0, e[39:32]});
        check("write_data", {8'b0, data_s}, {8'b0, e[31:0]});
      end
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_ptr = '0;
    check("start_in_ready", rdy_s, 1);
    check("start_busy", busy_s, 1);
    check("start_done", done_s, 0);
    check("start_overflow", ovf_s, 0);
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    in_valid = 1'b1;
    in_data = d;
    in_last = last;
    exp_q.push_back({exp_ptr, d});
    exp_ptr++;
    #2;
    check("word_in_ready", rdy_s, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  typedef struct {
    int          n;
    logic [31:0] base;
    int          gap_mode;   // 0 back-to-back, 1 alternate, 2 random gaps
    bit          use4;
    logic [7:0]  exp_last;
    logic        exp_done;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; sel = 1'b0;
    exp_ptr = '0;
    vecs[0] = '{4,   32'hA0,   0, 1'b0, 8'd3,   1'b1, 1'b0};
    vecs[1] = '{4,   32'hA0,   1, 1'b0, 8'd3,   1'b1, 1'b0};
    vecs[2] = '{1,   32'h55,   0, 1'b0, 8'd0,   1'b1, 1'b0};
    vecs[3] = '{16,  32'h100,  0, 1'b1, 8'd15,  1'b1, 1'b0};
    vecs[4] = '{256, 32'h1000, 0, 1'b0, 8'd255, 1'b1, 1'b0};
    vecs[5] = '{10,  $urandom, 2, 1'b0, 8'd9,   1'b1, 1'b0};

    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst_in_ready", rdy_s, 0);
      check("rst_mem_we", we_s, 0);
      check("rst_mem_addr", addr_s, 0);
      check("rst_mem_wdata", data_s, 0);
      check("rst_last_addr", last_s, 0);
      check("rst_done", done_s, 0);
      check("rst_overflow", ovf_s, 0);
      check("rst_busy", busy_s, 0);
      check("rst_state", st_s, 0);
    end
    sel = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", rdy_s, 0);

    for (int v = 0; v < 6; v++) begin
      sel = vecs[v].use4;
      do_start();
      for (int i = 0; i < vecs[v].n; i++) begin
        send_word(vecs[v].base + i, i == vecs[v].n - 1);
        if (i != vecs[v].n - 1) begin
          if (vecs[v].gap_mode == 1) begin
            @(posedge clk); #1;
          end else if (vecs[v].gap_mode == 2) begin
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk); #1;
            end
          end
        end
      end
      #2;
      check("flush_busy", busy_s, 1);
      check("flush_in_ready", rdy_s, 0);
      check("flush_done", done_s, 0);
      @(posedge clk); #1;
      check("vec_done", done_s, vecs[v].exp_done);
      check("vec_overflow", ovf_s, vecs[v].exp_ovf);
      check("vec_last_addr", last_s, vecs[v].exp_last);
      check("vec_busy", busy_s, 0);
      check("vec_writes_drained", exp_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
      check("done_hold", done_s, 1);
      check("last_addr_hold", last_s, vecs[v].exp_last);
    end

    // Overflow on the 4-bit instance: 16 words without in_last, then a refused 17th
    sel = 1'b1;
    do_start();
    for (int i = 0; i < 16; i++) send_word(32'h200 + i, 1'b0);
    #2;
    check("ovf_overflow", ovf_s, 1);
    check("ovf_in_ready", rdy_s, 0);
    check("ovf_done", done_s, 0);
    check("ovf_busy", busy_s, 0);
    check("ovf_last_addr", last_s, 15);
    in_valid = 1'b1; in_data = 32'hDEAD; in_last = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("ovf_17th_refused", rdy_s, 0);
    end
    in_valid = 1'b0;
    check("ovf_writes_drained", exp_q.size(), 0);
    check("ovf_holds", ovf_s, 1);
    do_start();
    send_word(32'h77, 1'b1);
    @(posedge clk); #1;
    check("ovf_recover_done", done_s, 1);
    check("ovf_recover_last", last_s, 0);

    // Reset in the middle of a 5-word load on the 8-bit instance
    sel = 1'b0;
    do_start();
    send_word(32'hB0, 1'b0);
    send_word(32'hB1, 1'b0);
    in_valid = 1'b1; in_data = 32'hB2;
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_mem_we", we_s, 0);
    check("midrst_mem_addr", addr_s, 0);
    check("midrst_mem_wdata", data_s, 0);
    check("midrst_last_addr", last_s, 0);
    check("midrst_in_ready", rdy_s, 0);
    check("midrst_done", done_s, 0);
    check("midrst_overflow", ovf_s, 0);
    check("midrst_busy", busy_s, 0);
    begin
      int seen_before;
      seen_before = wr_seen;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("midrst_no_write", wr_seen, seen_before);
    end
    check("midrst_idle", st_s, 0);
    do_start();
    for (int i = 0; i < 3; i++) send_word(32'hC0 + i, i == 2);
    @(posedge clk); #1;
    check("post_rst_done", done_s, 1);
    check("post_rst_last", last_s, 2);
    check("post_rst_drained", exp_q.size(), 0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
